axis_join_sequencer: RTL
========================

// Module: axis_join_sequencer
// PURPOSE
//  Job scheduler sitting in front of the multi-channel AXIS packet joiner. Queues channel-mask jobs
//  submitted by a control master and issues them one at a time as operation_start/use_channels.
//  Tracks each job to completion, error, timeout or abort, and reports a status record per job.
//  Drives the joiner's lock (pause) and interrupt (abort/timeout recovery) inputs.
// PARAMETERS
//  CHANNELS       2   joiner channel count; width of job masks
//  QUEUE_DEPTH    4   job FIFO entries; power of two, >=2
//  TIMEOUT_WIDTH  16  width of timeout_limit and the idle-cycle counter
//  COUNT_WIDTH    16  width of done_count / err_count
// PORTS
//  clk                 in   1              clock, rising edge
//  rst                 in   1              asynchronous, active-high reset
//  cmd_mask            in   CHANNELS       job channel mask
//  cmd_valid           in   1              job submit valid
//  cmd_ready           out  1              job accepted when valid&&ready
//  pause               in   1              hold the current job; forwarded as lock
//  abort               in   1              kill the in-flight job (1-cycle pulse sufficient)
//  timeout_limit       in   TIMEOUT_WIDTH  max cycles busy without a beat; 0 disables timeout
//  operation_start     out  1              to joiner
//  use_channels        out  CHANNELS       to joiner; valid while operation_start=1
//  lock                out  1              to joiner
//  interrupt           out  1              to joiner; 1-cycle pulse
//  operation_busy      in   1              from joiner
//  operation_complete  in   1              from joiner
//  operation_error     in   1              from joiner
//  transmission        in   1              from joiner; beat transferred last cycle
//  sts_valid           out  1              1-cycle pulse per finished job
//  sts_code            out  2              0 OK, 1 ERR, 2 TIMEOUT, 3 ABORT
//  sts_mask            out  CHANNELS       mask of the finished job
//  done_count          out  COUNT_WIDTH    jobs with code OK; saturating
//  err_count           out  COUNT_WIDTH    jobs with code ERR/TIMEOUT/ABORT; saturating
//  idle                out  1              FSM in IDLE and queue empty
// BEHAVIOUR
//  - Reset (async assert, sync deassert by design): all outputs 0 except cmd_ready=1, idle=1;
//    queue emptied, counters 0, FSM=IDLE. Reset mid-job: no interrupt or status is emitted.
//  - Queue: cmd_ready = !full (from registered occupancy only; no push-through when full, even
//    if a pop occurs that cycle). Push and pop in the same cycle are legal when not full or empty.
//  - All joiner-side and status outputs are registered.
//  - FSM: IDLE -> ISSUE when queue non-empty and pause=0.
//    ISSUE (1 cycle): operation_start=1, use_channels=head mask; head latched into job_mask -> WAIT.
//    WAIT: first match wins: operation_complete -> REPORT(OK);
//          operation_error -> REPORT(ERR); abort -> interrupt=1, REPORT(ABORT);
//          idle_cnt==timeout_limit (limit!=0) -> interrupt=1, REPORT(TIMEOUT).
//    REPORT (1 cycle): pop queue, sts_valid=1 with code/job_mask, bump counter -> RECOVER.
//    RECOVER (1 cycle, lets joiner return to start state) -> IDLE, or -> ISSUE if queue non-empty
//    and pause=0. Back-to-back jobs: operation_start pulses spaced by 4 cycles minimum.
//  - Mask 0 jobs are issued unchanged; the joiner's operation_error yields code ERR.
//  - idle_cnt: cleared on entering WAIT and on every transmission=1; increments in WAIT while
//    pause=0 and operation_busy=1; frozen while pause=1; saturates at all-ones.
//  - lock = pause, registered; asserted in any state. Pause in IDLE/RECOVER blocks new issues.
//  - abort outside WAIT is ignored. interrupt is never asserted outside WAIT->REPORT transition.
//  - Counters saturate at 2^COUNT_WIDTH-1, never wrap.
// STRUCTURE
//  - join_seq_defs.vh: FSM state localparams (IDLE, ISSUE, WAIT, REPORT, RECOVER, 3-bit) and
//    STS_OK/STS_ERR/STS_TIMEOUT/STS_ABORT codes; LOG2 taken from header_utils.vh.
//  - Sub-module axis_join_cmd_fifo: synchronous FIFO, width CHANNELS, depth QUEUE_DEPTH,
//    registered full/empty, async reset. FSM, timeout counter and status logic stay in top.
// TESTING
//  1 Single job mask=2'b11, joiner model completes after 10 beats -> start pulse 1 cycle after
//    accept+IDLE, one sts_valid code=0 mask=11, done_count=1, idle=1 afterwards.
//  2 Push 5 jobs back-to-back with QUEUE_DEPTH=4 -> 5th held (cmd_ready=0) until first REPORT
//    pop; all 5 issued in order, start pulses >=4 cycles apart.
//  3 Job mask=0 -> joiner operation_error -> sts_code=1, err_count=1, no interrupt pulse.
//  4 timeout_limit=8, joiner busy with no transmission -> interrupt pulse after 8 busy cycles,
//    sts_code=2; repeat with pause held 20 cycles mid-job -> no timeout during pause.
//  5 abort pulse in WAIT same cycle as operation_complete -> code 0, no interrupt; abort alone
//    -> interrupt 1 cycle, code 3, next queued job issued after RECOVER.
//  6 rst asserted mid-WAIT with 3 jobs queued -> outputs reset immediately (asynchronously),
//    queue empty, no sts_valid, counters 0.

Source files
------------

// File: rtl/axis_join_sequencer_pkg.sv
// Package: axis_join_sequencer_pkg
// Purpose: shared types for the AXIS join sequencer slice -- the scheduler
//          FSM state encoding, the per-job status codes reported on sts_code,
//          and a ceiling-log2 helper used to size FIFO pointers.
// Ports:   none (package)
package axis_join_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_REPORT  = 3'd3,
    ST_RECOVER = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    STS_OK      = 2'd0,
    STS_ERR     = 2'd1,
    STS_TIMEOUT = 2'd2,
    STS_ABORT   = 2'd3
  } sts_code_t;

  // Returns ceil(log2(value)), with a floor of 1 so a pointer is never 0 bits.
  function automatic int log2ceil(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axis_join_cmd_fifo.sv
// Module: axis_join_cmd_fifo
// Purpose: synchronous job FIFO holding channel masks for the join sequencer.
//          Full/empty are registered flags derived from the next occupancy, so
//          consumers only ever see occupancy as of the last clock edge.
// Ports:
//   clk        in  1      clock, rising edge
//   rst        in  1      asynchronous, active-high reset (empties the FIFO)
//   push       in  1      write request; ignored while full
//   push_data  in  WIDTH  data to write
//   pop        in  1      read request; ignored while empty
//   pop_data   out WIDTH  head entry (valid while empty=0)
//   full       out 1      registered full flag
//   empty      out 1      registered empty flag
module axis_join_cmd_fifo
  import axis_join_sequencer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = log2ceil(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  // Storage carries no reset; only pointers and flags define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/axis_join_sequencer.sv
// Module: axis_join_sequencer
// Purpose: job scheduler in front of the multi-channel AXIS packet joiner.
//          Queues channel-mask jobs, issues them one at a time, tracks each
//          to completion/error/timeout/abort and reports one status per job.
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   cmd_mask/cmd_valid/cmd_ready  job submission handshake
//   pause                         hold current job, block new issues (-> lock)
//   abort                         kill the in-flight job while waiting
//   timeout_limit                 busy cycles without a beat before timeout; 0 = off
//   operation_start/use_channels  issue strobe and mask to the joiner
//   lock/interrupt                pause and recovery controls to the joiner
//   operation_busy/_complete/_error/transmission   joiner feedback
//   sts_valid/sts_code/sts_mask   per-job status pulse
//   done_count/err_count          saturating OK / non-OK job counters
//   idle                          FSM idle and queue empty
module axis_join_sequencer
  import axis_join_sequencer_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int QUEUE_DEPTH   = 4,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      cmd_mask,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     pause,
  input  logic                     abort,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
  output logic                     operation_start,
  output logic [CHANNELS-1:0]      use_channels,
  output logic                     lock,
  output logic                     interrupt,
  input  logic                     operation_busy,
  input  logic                     operation_complete,
  input  logic                     operation_error,
  input  logic                     transmission,
  output logic                     sts_valid,
  output logic [1:0]               sts_code,
  output logic [CHANNELS-1:0]      sts_mask,
  output logic [COUNT_WIDTH-1:0]   done_count,
  output logic [COUNT_WIDTH-1:0]   err_count,
  output logic                     idle
);

  state_t                   state;
  state_t                   state_next;
  sts_code_t                code_q;
  sts_code_t                code_next;
  logic                     irq_next;
  logic                     enter_report;
  logic [CHANNELS-1:0]      job_mask;
  logic [CHANNELS-1:0]      fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [TIMEOUT_WIDTH-1:0] idle_cnt;

  // The head entry stays in the FIFO for the whole job and is popped in
  // REPORT, so a full queue cannot accept a new job until that pop lands.
  axis_join_cmd_fifo #(
    .WIDTH (CHANNELS),
    .DEPTH (QUEUE_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data (cmd_mask),
    .pop       (state == ST_REPORT),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign idle      = (state == ST_IDLE) && fifo_empty;
  assign sts_code  = code_q;

  always_comb begin
    state_next   = state;
    code_next    = code_q;
    irq_next     = 1'b0;
    enter_report = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty && !pause) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion beats error beats abort beats timeout.
        if (operation_complete) begin
          state_next = ST_REPORT;
          code_next  = STS_OK;
        end else if (operation_error) begin
          state_next = ST_REPORT;
          code_next  = STS_ERR;
        end else if (abort) begin
          state_next = ST_REPORT;
          code_next  = STS_ABORT;
          irq_next   = 1'b1;
        end else if ((timeout_limit != '0) && (idle_cnt == timeout_limit)) begin
          state_next = ST_REPORT;
          code_next  = STS_TIMEOUT;
          irq_next   = 1'b1;
        end
        enter_report = (state_next == ST_REPORT);
      end
      ST_REPORT: begin
        state_next = ST_RECOVER;
      end
      ST_RECOVER: begin
        // fifo_empty here already reflects the pop made in REPORT.
        if (!fifo_empty && !pause) begin
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Joiner-side and status outputs are registered from the next-state
  // decode, so each is asserted exactly during its matching state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      code_q          <= STS_OK;
      job_mask        <= '0;
      operation_start <= 1'b0;
      use_channels    <= '0;
      lock            <= 1'b0;
      interrupt       <= 1'b0;
      sts_valid       <= 1'b0;
      sts_mask        <= '0;
      done_count      <= '0;
      err_count       <= '0;
    end else begin
      state           <= state_next;
      operation_start <= (state_next == ST_ISSUE);
      use_channels    <= (state_next == ST_ISSUE) ? fifo_head : '0;
      lock            <= pause;
      interrupt       <= irq_next;
      sts_valid       <= enter_report;
      if (state == ST_ISSUE) begin
        job_mask <= fifo_head;
      end
      if (enter_report) begin
        code_q   <= code_next;
        sts_mask <= job_mask;
        if (code_next == STS_OK) begin
          if (done_count != '1) begin
            done_count <= done_count + 1'b1;
          end
        end else if (err_count != '1) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

  // Busy cycles without a beat; paused cycles do not count toward timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if ((state == ST_ISSUE) || transmission) begin
      idle_cnt <= '0;
    end else if ((state == ST_WAIT) && !pause && operation_busy && (idle_cnt != '1)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule
